adder_arbiter: RTL

Shares one pipelined wide `adder` instance between `NREQ` requesters. Each cycle it selects at most one pending request, registers its operands into the adder, and tracks a valid/requester-ID tag through a shift pipeline matched to the adder latency. When the sum emerges, the tag labels it, so each result returns to its originator. The block sits between the wide-operand producers and the shared adder, replacing per-requester adder instances.

---
 rtl/adder_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one pipelined wide adder among NREQ requesters.
// Each cycle at most one pending request is granted. Its operands are registered into
// the adder. A valid/ID tag travels alongside so each sum returns labelled with its
// requester. Latency from accept to rsp_valid is 1+ADDER_LATENCY cycles. The pipeline
// never stalls, and the consumer must take rsp_* in the cycle rsp_valid is high.
// Arbitration is round-robin when ADDER_ARB_RR_EN is defined, and fixed priority
// (lowest index wins) otherwise.
// Ports: clk/resetn (synchronous, active-low); req_valid/req_a/req_b/req_cin/req_ready
// (requester side); add_a/add_b/add_cin/add_out/add_cout (adder side);
// rsp_valid/rsp_id/rsp_sum/rsp_cout (result); inflight (count of valid tags in the
// pipeline, saturating at ADDER_LATENCY).
module adder_arbiter #(
  parameter int NREQ          = 4,
  parameter int ADDER_SIZE    = 1024,
  parameter int ADDER_LATENCY = 2,
  parameter int IDW           = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDER_SIZE-1:0] req_a,
  input  logic [NREQ*ADDER_SIZE-1:0] req_b,
  input  logic [NREQ-1:0]            req_cin,
  output logic [NREQ-1:0]            req_ready,
  output logic [ADDER_SIZE-1:0]      add_a,
  output logic [ADDER_SIZE-1:0]      add_b,
  output logic                       add_cin,
  input  logic [ADDER_SIZE-1:0]      add_out,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [ADDER_SIZE-1:0]      rsp_sum,
  output logic                       rsp_cout,
  output logic [IDW:0]               inflight
);

  localparam int CW = IDW + 1;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            accept;

  // Stage 0 is the issue register, aligned with add_a/add_b. Stages 1..ADDER_LATENCY
  // follow the adder, so the last stage lines up with add_out.
  logic [ADDER_LATENCY:0] tag_v;
  logic [IDW-1:0]         tag_id [0:ADDER_LATENCY];

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
`endif

  // Grant search. The search starts at the round-robin pointer, or at index 0 for
  // fixed priority. The first valid requester found wins.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_RR_EN
      idx = (int'(rr_ptr) + i) % NREQ;
`else
      idx = i;
`endif
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        win        = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      tag_v   <= '0;
      for (int i = 0; i <= ADDER_LATENCY; i++) tag_id[i] <= '0;
`ifdef ADDER_ARB_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      // Operands hold when idle. Only the tag marks whether add_out is meaningful.
      if (accept) begin
        add_a   <= req_a[int'(win)*ADDER_SIZE +: ADDER_SIZE];
        add_b   <= req_b[int'(win)*ADDER_SIZE +: ADDER_SIZE];
        add_cin <= req_cin[win];
`ifdef ADDER_ARB_RR_EN
        if (win == IDW'(NREQ-1)) rr_ptr <= '0;
        else                     rr_ptr <= win + 1'b1;
`endif
      end
      tag_v     <= {tag_v[ADDER_LATENCY-1:0], accept};
      tag_id[0] <= win;
      for (int i = 1; i <= ADDER_LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  // Popcount of all tag stages. This count can reach ADDER_LATENCY+1 under
  // back-to-back traffic, so it is clamped.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i <= ADDER_LATENCY; i++) cnt += int'(tag_v[i]);
    inflight = (cnt > ADDER_LATENCY) ? CW'(ADDER_LATENCY) : CW'(cnt);
  end

  assign rsp_valid = tag_v[ADDER_LATENCY];
  assign rsp_id    = tag_id[ADDER_LATENCY];
  assign rsp_sum   = add_out;
  assign rsp_cout  = add_cout;

endmodule
